// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer:
// FSM state encoding, table end marker, register addresses and bus-drive helpers.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STRT   = 3'd2,
        ST_BITS   = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5,
        ST_SETTLE = 3'd6,
        ST_FIN    = 3'd7
    } sccb_state_t;

    localparam logic [15:0] END_MARKER = 16'hFFFF;

    localparam logic [7:0] REG_CLKRC  = 8'h11;
    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_COM3   = 8'h0C;
    localparam logic [7:0] REG_COM9   = 8'h14;
    localparam logic [7:0] REG_TSLB   = 8'h3A;
    localparam logic [7:0] REG_COM14  = 8'h3E;
    localparam logic [7:0] REG_COM15  = 8'h40;
    localparam logic [7:0] REG_RGB444 = 8'h8C;

    localparam logic [4:0] LAST_BIT = 5'd26;

    // Bit slots 9, 18 and 27 (zero-based 8, 17, 26) are the slave's ACK windows.
    function automatic logic is_ack_slot(input logic [4:0] bit_idx);
        return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    endfunction

    // Bus levels {sioc, siod_out, siod_oe} for one quarter of a phase.
    function automatic logic [2:0] bus_drive(input sccb_state_t st, input logic [1:0] q,
                                             input logic bit_val, input logic ack);
        logic [2:0] drv;
        case (st)
            ST_STRT: begin
                case (q)
                    2'd0:    drv = 3'b111;
                    2'd3:    drv = 3'b001;
                    default: drv = 3'b101;
                endcase
            end
            ST_BITS: drv = {q[1], (ack ? 1'b1 : bit_val), ~ack};
            ST_STOP: begin
                case (q)
                    2'd0:    drv = 3'b001;
                    2'd3:    drv = 3'b111;
                    default: drv = 3'b101;
                endcase
            end
            default: drv = 3'b110;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/camera_reg_rom.sv
// OV7670 power-up register table: index -> {addr, data}, terminated by the end marker.
// ROM_SEL 1 and 2 select the short bring-up tables used on the bench.
module camera_reg_rom
    import cam_pkg::*;
#(
    parameter logic [1:0] ROM_SEL = 2'd0
) (
    input  logic [7:0]  i_index,
    output logic [15:0] o_entry
);

    // Table lookup; anything past the listed entries reads as the end marker.
    always_comb begin
        o_entry = END_MARKER;
        case (ROM_SEL)
            2'd1: begin
                case (i_index)
                    8'd0:    o_entry = {REG_COM7, 8'h80};
                    8'd1:    o_entry = {REG_CLKRC, 8'h01};
                    default: o_entry = END_MARKER;
                endcase
            end
            2'd2: o_entry = END_MARKER;
            default: begin
                case (i_index)
                    8'd0:    o_entry = {REG_COM7, 8'h80};
                    8'd1:    o_entry = {REG_CLKRC, 8'h01};
                    8'd2:    o_entry = {REG_COM7, 8'h04};
                    8'd3:    o_entry = {REG_COM3, 8'h00};
                    8'd4:    o_entry = {REG_COM14, 8'h00};
                    8'd5:    o_entry = {REG_COM15, 8'hD0};
                    8'd6:    o_entry = {REG_RGB444, 8'h00};
                    8'd7:    o_entry = {REG_TSLB, 8'h04};
                    8'd8:    o_entry = {REG_COM9, 8'h18};
                    default: o_entry = END_MARKER;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/camera_sccb_config.sv
// OV7670 configuration sequencer: walks the register table and issues one SCCB
// 3-phase write per entry, raising a sticky DONE when the table is exhausted.
module camera_sccb_config
    import cam_pkg::*;
#(
    parameter int         CLK_HZ     = 25_000_000,
    parameter int         SCCB_HZ    = 100_000,
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         NUM_REGS   = 32,
    parameter int         SETTLE_CYC = 25_000,
    parameter logic [1:0] ROM_SEL    = 2'd0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic                        o_sioc,
    output logic                        o_siod_out,
    output logic                        o_siod_oe,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(NUM_REGS)-1:0] o_reg_index
);

    localparam int QDIV_RAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int SW       = $clog2(SETTLE_CYC + 1);
    localparam int IW       = $clog2(NUM_REGS);

    localparam logic [QW-1:0] Q_LAST = QW'(QDIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_REGS - 1);

    sccb_state_t   r_state;
    logic [1:0]    r_q;
    logic [QW-1:0] r_qcnt;
    logic [4:0]    r_bit;
    logic [26:0]   r_shift;
    logic [SW-1:0] r_settle;
    logic [IW-1:0] r_idx;
    logic          r_sioc;
    logic          r_siod;
    logic          r_oe;
    logic          r_busy;
    logic          r_done;

    logic [7:0]  w_rom_addr;
    logic [15:0] w_rom_entry;
    logic [26:0] w_frame;
    logic        w_bus_phase;
    logic        w_tick;

    assign w_rom_addr  = 8'(r_idx);
    assign w_frame     = {DEV_ID, 1'b1, w_rom_entry[15:8], 1'b1, w_rom_entry[7:0], 1'b1};
    assign w_bus_phase = (r_state == ST_STRT) || (r_state == ST_BITS) ||
                         (r_state == ST_STOP) || (r_state == ST_GAP);
    assign w_tick      = (r_qcnt == Q_LAST);

    assign o_sioc      = r_sioc;
    assign o_siod_out  = r_siod;
    assign o_siod_oe   = r_oe;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_reg_index = r_idx;

    camera_reg_rom #(.ROM_SEL(ROM_SEL)) u_rom (
        .i_index (w_rom_addr),
        .o_entry (w_rom_entry)
    );

    // Quarter-bit divider, held at zero outside bus phases so each write starts aligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_qcnt <= {QW{1'b0}};
        end else if (!w_bus_phase || w_tick) begin
            r_qcnt <= {QW{1'b0}};
        end else begin
            r_qcnt <= r_qcnt + QW'(1);
        end
    end

    // Sequencer FSM; bus levels are registered for the quarter being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_q      <= 2'd0;
            r_bit    <= 5'd0;
            r_shift  <= {27{1'b1}};
            r_settle <= {SW{1'b0}};
            r_idx    <= {IW{1'b0}};
            {r_sioc, r_siod, r_oe} <= 3'b110;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    {r_sioc, r_siod, r_oe} <= 3'b110;
                    if (i_start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_idx   <= {IW{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_q   <= 2'd0;
                    r_bit <= 5'd0;
                    if (w_rom_entry == END_MARKER) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_shift <= w_frame;
                        r_state <= ST_STRT;
                        {r_sioc, r_siod, r_oe} <= bus_drive(ST_STRT, 2'd0, 1'b1, 1'b0);
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == S_LAST) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        {r_sioc, r_siod, r_oe} <= bus_drive(r_state, r_q + 2'd1, r_shift[26],
                                                            is_ack_slot(r_bit));
                        if (r_q == 2'd3) begin
                            case (r_state)
                                ST_STRT: begin
                                    r_state <= ST_BITS;
                                    {r_sioc, r_siod, r_oe} <= bus_drive(ST_BITS, 2'd0, r_shift[26],
                                                                        is_ack_slot(5'd0));
                                end
                                ST_BITS: begin
                                    if (r_bit == LAST_BIT) begin
                                        r_state <= ST_STOP;
                                        {r_sioc, r_siod, r_oe} <= bus_drive(ST_STOP, 2'd0, 1'b1, 1'b0);
                                    end else begin
                                        r_bit   <= r_bit + 5'd1;
                                        r_shift <= {r_shift[25:0], 1'b1};
                                        {r_sioc, r_siod, r_oe} <= bus_drive(ST_BITS, 2'd0, r_shift[25],
                                                                            is_ack_slot(r_bit + 5'd1));
                                    end
                                end
                                ST_STOP: begin
                                    r_state <= ST_GAP;
                                    {r_sioc, r_siod, r_oe} <= bus_drive(ST_GAP, 2'd0, 1'b1, 1'b0);
                                end
                                default: begin
                                    // End of GAP: the COM7 soft reset needs settling time.
                                    if (r_idx == I_LAST) begin
                                        r_state <= ST_FIN;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end else begin
                                        r_idx <= r_idx + IW'(1);
                                        if (r_idx == {IW{1'b0}}) begin
                                            r_state  <= ST_SETTLE;
                                            r_settle <= {SW{1'b0}};
                                        end else begin
                                            r_state <= ST_LOAD;
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_sccb_config.sv
// Directed bench for camera_sccb_config with an SCCB slave decoder on SIOC/SIOD.
// QDIV=1, SETTLE_CYC=8, table {12,80},{11,01},{FF,FF}; a second instance has an empty table.
`timescale 1ns/1ps
module tb_camera_sccb_config;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0;
    logic       sioc, siod, oe, busy, done;
    logic [4:0] idx;
    logic       rst2 = 1'b1, start2 = 1'b0;
    logic       sioc2, siod2, oe2, busy2, done2;
    logic [4:0] idx2;

    int total = 0;
    int bad   = 0;

    // START edge -> LOAD(1) + write0(120) + SETTLE(8) + LOAD(1) + write1(120) + LOAD of marker(1)
    localparam int DONE_CYC = 251;
    logic [7:0] exp_b [0:5] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01};

    camera_sccb_config #(.CLK_HZ(4), .SCCB_HZ(1), .DEV_ID(8'h42), .NUM_REGS(32),
                         .SETTLE_CYC(8), .ROM_SEL(2'd1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_sioc(sioc), .o_siod_out(siod),
        .o_siod_oe(oe), .o_busy(busy), .o_done(done), .o_reg_index(idx));

    camera_sccb_config #(.CLK_HZ(4), .SCCB_HZ(1), .DEV_ID(8'h42), .NUM_REGS(32),
                         .SETTLE_CYC(8), .ROM_SEL(2'd2)) dut_empty (
        .i_clk(clk), .i_rst(rst2), .i_start(start2), .o_sioc(sioc2), .o_siod_out(siod2),
        .o_siod_oe(oe2), .o_busy(busy2), .o_done(done2), .o_reg_index(idx2));

    logic mon_clr = 1'b0;
    logic p_sioc = 1'b1, p_sda = 1'b1, pend = 1'b0, pbit = 1'b0, poe = 1'b0;
    int bitcnt = 0, frame_rises = 0, any_rises = 0, starts = 0, stops = 0, oe_err = 0, ack_err = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] byte_q [$];
    int idx_q [$];
    int rise_q [$];
    int rises2 = 0;
    logic p_sioc2 = 1'b1;

    // Slave decoder: data bits latched on SIOC rise, committed on the following fall.
    always @(negedge clk) begin
        logic sda;
        sda = oe ? siod : 1'b1;
        if (mon_clr) begin
            bitcnt = 0; frame_rises = 0; any_rises = 0; starts = 0; stops = 0;
            oe_err = 0; ack_err = 0; pend = 1'b0;
            byte_q.delete(); idx_q.delete(); rise_q.delete();
            p_sioc = sioc; p_sda = sda;
        end else if (rst) begin
            p_sioc = 1'b1; p_sda = 1'b1; pend = 1'b0;
        end else begin
            if (p_sioc && sioc && p_sda && !sda) begin
                starts++; bitcnt = 0; frame_rises = 0; pend = 1'b0; idx_q.push_back(int'(idx));
            end
            if (p_sioc && sioc && !p_sda && sda) begin
                stops++; pend = 1'b0; rise_q.push_back(frame_rises);
            end
            if (!p_sioc && sioc) begin
                any_rises++; pend = 1'b1; pbit = sda; poe = oe;
            end
            if (p_sioc && !sioc && pend) begin
                pend = 1'b0; bitcnt++; frame_rises++;
                if (bitcnt % 9 == 0) begin
                    if (poe) ack_err++;
                    byte_q.push_back(cur);
                end else begin
                    if (!poe) oe_err++;
                    cur = {cur[6:0], pbit};
                end
            end
            p_sioc = sioc; p_sda = sda;
        end
    end

    always @(negedge clk) begin
        if (mon_clr) rises2 = 0;
        else if (!p_sioc2 && sioc2) rises2++;
        p_sioc2 = sioc2;
    end

    task automatic clear_mon();
        @(negedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic run_seq(input bit noisy, output int cycles, output logic busy0, output logic done0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy0 = busy; done0 = done;
        cycles = 0;
        while (done !== 1'b1 && cycles < 600) begin
            if (noisy && (cycles == 5 || cycles == 60 || cycles == 125 || cycles == 200 || cycles == 250))
                start = 1'b1;
            else
                start = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input int n);
        logic [7:0] got;
        total++;
        if (byte_q.size() < n) begin bad++; $display("FAIL %s_count: got %0d want >=%0d", tag, byte_q.size(), n); end
        for (int i = 0; i < n; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            total++;
            if (got !== exp_b[i]) begin bad++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, got, exp_b[i]); end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (sioc !== 1'b1) begin bad++; $display("FAIL rst_hold_sioc: got %b want 1", sioc); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL rst_hold_oe: got %b want 0", oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_hold_busy: got %b want 0", busy); end
        @(negedge clk); rst = 1'b0; rst2 = 1'b0;
        clear_mon();
        repeat (50) @(posedge clk);
        #1;
        total++; if (sioc !== 1'b1) begin bad++; $display("FAIL idle_sioc: got %b want 1", sioc); end
        total++; if (siod !== 1'b1) begin bad++; $display("FAIL idle_siod: got %b want 1", siod); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL idle_oe: got %b want 0", oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_done: got %b want 0", done); end
        total++; if (idx !== 5'd0) begin bad++; $display("FAIL idle_index: got %0d want 0", idx); end
        total++; if (any_rises !== 0) begin bad++; $display("FAIL idle_edges: got %0d want 0", any_rises); end
    endtask

    task automatic test_sequence();
        int cyc; logic b0, d0;
        clear_mon();
        run_seq(1'b0, cyc, b0, d0);
        total++; if (b0 !== 1'b1) begin bad++; $display("FAIL seq_busy_next: got %b want 1", b0); end
        total++; if (d0 !== 1'b0) begin bad++; $display("FAIL seq_done_low: got %b want 0", d0); end
        total++; if (cyc !== DONE_CYC) begin bad++; $display("FAIL seq_done_time: got %0d want %0d", cyc, DONE_CYC); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL seq_busy_end: got %b want 0", busy); end
        check_bytes("seq", 6);
        total++; if (idx_q.size() !== 2) begin bad++; $display("FAIL seq_idx_count: got %0d want 2", idx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= idx_q.size() || idx_q[i] !== i) begin
                bad++; $display("FAIL seq_idx%0d: got %0d want %0d", i, (i < idx_q.size()) ? idx_q[i] : -1, i);
            end
        end
    endtask

    task automatic test_bus_shape();
        int cyc; logic b0, d0;
        clear_mon();
        run_seq(1'b0, cyc, b0, d0);
        total++; if (rise_q.size() !== 2) begin bad++; $display("FAIL shape_frames: got %0d want 2", rise_q.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= rise_q.size() || rise_q[i] !== 27) begin
                bad++; $display("FAIL shape_rises%0d: got %0d want 27", i, (i < rise_q.size()) ? rise_q[i] : -1);
            end
        end
        total++; if (starts !== 2) begin bad++; $display("FAIL shape_starts: got %0d want 2", starts); end
        total++; if (stops !== 2) begin bad++; $display("FAIL shape_stops: got %0d want 2", stops); end
        total++; if (ack_err !== 0) begin bad++; $display("FAIL shape_ack_oe: got %0d want 0", ack_err); end
        total++; if (oe_err !== 0) begin bad++; $display("FAIL shape_data_oe: got %0d want 0", oe_err); end
    endtask

    task automatic test_ignored_start();
        int cyc; logic b0, d0;
        clear_mon();
        run_seq(1'b1, cyc, b0, d0);
        total++; if (cyc !== DONE_CYC) begin bad++; $display("FAIL ign_done_time: got %0d want %0d", cyc, DONE_CYC); end
        check_bytes("ign", 6);
        total++; if (starts !== 2) begin bad++; $display("FAIL ign_starts: got %0d want 2", starts); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after: got %b want 0", busy); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done_sticky: got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        int cyc, n; logic b0, d0; bit reached;
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0; reached = 1'b0;
        while (!reached && n < 400) begin
            @(posedge clk); #1;
            n++;
            reached = (starts == 1 && frame_rises >= 12);
        end
        total++; if (!reached) begin bad++; $display("FAIL rmid_reach_bit12: got %0d rises want 12", frame_rises); end
        #2 rst = 1'b1;
        #1;
        total++; if (sioc !== 1'b1) begin bad++; $display("FAIL rmid_sioc: got %b want 1", sioc); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL rmid_oe: got %b want 0", oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (idx !== 5'd0) begin bad++; $display("FAIL rmid_index: got %0d want 0", idx); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        run_seq(1'b0, cyc, b0, d0);
        total++; if (cyc !== DONE_CYC) begin bad++; $display("FAIL rmid_replay_time: got %0d want %0d", cyc, DONE_CYC); end
        check_bytes("rmid", 3);
        total++;
        if (idx_q.size() == 0 || idx_q[0] !== 0) begin
            bad++; $display("FAIL rmid_replay_idx: got %0d want 0", (idx_q.size() > 0) ? idx_q[0] : -1);
        end
    endtask

    task automatic test_empty_rom();
        int n; bit busy_ok;
        clear_mon();
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        busy_ok = (n >= 1 && n <= 3);
        total++; if (!busy_ok) begin bad++; $display("FAIL empty_busy_len: got %0d want 1..3", n); end
        total++; if (done2 !== 1'b1) begin bad++; $display("FAIL empty_done: got %b want 1", done2); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (done2 !== 1'b1) begin bad++; $display("FAIL empty_done_sticky: got %b want 1", done2); end
        total++; if (rises2 !== 0) begin bad++; $display("FAIL empty_edges: got %0d want 0", rises2); end
        total++; if (oe2 !== 1'b0 || siod2 !== 1'b1 || idx2 !== 5'd0) begin
            bad++; $display("FAIL empty_bus: got oe=%b siod=%b idx=%0d want 0 1 0", oe2, siod2, idx2);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_bus_shape();
        test_ignored_start();
        test_reset_mid();
        test_empty_rom();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
